// File: rtl/syzygy_adc_pkg.sv
// Shared types and constants for the SYZYGY ADC frame-alignment controller.
package syzygy_adc_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WAIT   = 3'd1;
    localparam logic [2:0] ST_CHECK  = 3'd2;
    localparam logic [2:0] ST_SLIP   = 3'd3;
    localparam logic [2:0] ST_LOCKED = 3'd4;
    localparam logic [2:0] ST_FAIL   = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_WAIT   = ST_WAIT,
        S_CHECK  = ST_CHECK,
        S_SLIP   = ST_SLIP,
        S_LOCKED = ST_LOCKED,
        S_FAIL   = ST_FAIL
    } align_state_e;

    // ISERDES needs a few CLKDIV cycles before a slipped word is observable
    localparam int unsigned MIN_SLIP_WAIT = 4;
    localparam int unsigned RELOCK_CNT_W  = 8;

    function automatic logic [7:0] default_frame_pattern(input int unsigned serdes_width);
        return (serdes_width == 4) ? 8'h0C : 8'hF0;
    endfunction

endpackage

// File: rtl/syzygy_adc_if.sv
// Frame-alignment bus between the SYZYGY PHY wrapper (master) and the aligner (slave).
interface syzygy_adc_if
    import syzygy_adc_pkg::*;
#(
    parameter int unsigned SERDES_WIDTH = 8,
    parameter int unsigned NUM_LANES    = 4
);
    localparam int unsigned CNT_W = $clog2(SERDES_WIDTH);

    logic                    ena;
    logic [SERDES_WIDTH-1:0] frame_word;
    logic [NUM_LANES-1:0]    bitslip;
    logic [CNT_W-1:0]        bitslip_count;
    logic                    data_valid;
    logic                    locked;
    logic                    align_fail;
    logic [RELOCK_CNT_W-1:0] relock_count;

    modport master (
        output ena, frame_word,
        input  bitslip, bitslip_count, data_valid, locked, align_fail, relock_count
    );

    modport slave (
        input  ena, frame_word,
        output bitslip, bitslip_count, data_valid, locked, align_fail, relock_count
    );

endinterface

// File: rtl/syzygy_adc_frame_checker.sv
// Frame-word comparator with match/miss run-length counters.
// Miss counter is only built when FRAME_RELOCK_EN is defined.
module syzygy_adc_frame_checker
    import syzygy_adc_pkg::*;
#(
    parameter int unsigned SERDES_WIDTH  = 8,
    parameter logic [7:0]  FRAME_PATTERN = 8'hF0,
    parameter int unsigned CHECK_CYCLES  = 4,
    parameter int unsigned MISS_LIMIT    = 4
) (
    input  logic                    slow_clk,
    input  logic                    reset,
    input  logic [SERDES_WIDTH-1:0] frame_word,
    input  logic                    check_en,
    input  logic                    monitor_en,
    output logic                    frame_match_c,
    output logic                    match_done_c,
    output logic                    miss_done_c
);
    localparam logic [SERDES_WIDTH-1:0] PATTERN = FRAME_PATTERN[SERDES_WIDTH-1:0];
    localparam int unsigned MATCH_W = $clog2(CHECK_CYCLES + 1);

    logic [MATCH_W-1:0] match_cnt;

    assign frame_match_c = (frame_word == PATTERN);
    assign match_done_c  = check_en && frame_match_c
                         && (match_cnt == MATCH_W'(CHECK_CYCLES - 1));

    // Consecutive-match run; any gap or leaving CHECK restarts it
    always_ff @(posedge slow_clk or posedge reset) begin
        if (reset) begin
            match_cnt <= '0;
        end else if (check_en && frame_match_c && !match_done_c) begin
            match_cnt <= match_cnt + MATCH_W'(1);
        end else begin
            match_cnt <= '0;
        end
    end

`ifdef FRAME_RELOCK_EN
    localparam int unsigned MISS_W = $clog2(MISS_LIMIT + 1);

    logic [MISS_W-1:0] miss_cnt;

    assign miss_done_c = monitor_en && !frame_match_c
                       && (miss_cnt == MISS_W'(MISS_LIMIT - 1));

    // Consecutive-miss run while locked; a single good word clears it
    always_ff @(posedge slow_clk or posedge reset) begin
        if (reset) begin
            miss_cnt <= '0;
        end else if (monitor_en && !frame_match_c && !miss_done_c) begin
            miss_cnt <= miss_cnt + MISS_W'(1);
        end else begin
            miss_cnt <= '0;
        end
    end
`else
    logic unused_monitor_en;
    assign unused_monitor_en = monitor_en;
    assign miss_done_c       = 1'b0;
`endif

endmodule

// File: rtl/syzygy_adc_frame_align.sv
// Frame-alignment controller: slips all data-lane ISERDES until the frame word locks.
// Optional FRAME_RELOCK_EN adds loss-of-lock detection and automatic relock.
module syzygy_adc_frame_align
    import syzygy_adc_pkg::*;
#(
    parameter int unsigned SERDES_WIDTH  = 8,
    parameter logic [7:0]  FRAME_PATTERN = default_frame_pattern(SERDES_WIDTH),
    parameter int unsigned NUM_LANES     = 4,
    parameter int unsigned SLIP_WAIT     = 4,
    parameter int unsigned CHECK_CYCLES  = 4,
    parameter int unsigned MISS_LIMIT    = 4
) (
    input  logic         slow_clk,
    input  logic         reset,
    syzygy_adc_if.slave  bus
);
    localparam int unsigned CNT_W        = $clog2(SERDES_WIDTH);
    localparam int unsigned WAIT_CYCLES  = (SLIP_WAIT < MIN_SLIP_WAIT) ? MIN_SLIP_WAIT : SLIP_WAIT;
    localparam int unsigned WAIT_W       = $clog2(WAIT_CYCLES);
    localparam int unsigned MAX_ATTEMPTS = 2 * SERDES_WIDTH;
    localparam int unsigned ATT_W        = $clog2(MAX_ATTEMPTS + 1);

    align_state_e      state_q, state_n;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_n;
    logic [ATT_W-1:0]  attempts_q, attempts_n;
    logic [CNT_W-1:0]  slip_cnt_q, slip_cnt_n;
    logic              align_fail_q, align_fail_n;
    logic [NUM_LANES-1:0] bitslip_q;
    logic              locked_q;
    logic              data_valid_q;

    logic frame_match_c;
    logic match_done_c;
    logic miss_done_c;

    syzygy_adc_frame_checker #(
        .SERDES_WIDTH  (SERDES_WIDTH),
        .FRAME_PATTERN (FRAME_PATTERN),
        .CHECK_CYCLES  (CHECK_CYCLES),
        .MISS_LIMIT    (MISS_LIMIT)
    ) u_checker (
        .slow_clk      (slow_clk),
        .reset         (reset),
        .frame_word    (bus.frame_word),
        .check_en      (state_q == S_CHECK),
        .monitor_en    (state_q == S_LOCKED),
        .frame_match_c (frame_match_c),
        .match_done_c  (match_done_c),
        .miss_done_c   (miss_done_c)
    );

    // State register
    always_ff @(posedge slow_clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Next state and counter updates; a dropped enable overrides every decision
    always_comb begin
        state_n      = state_q;
        wait_cnt_n   = '0;
        attempts_n   = attempts_q;
        slip_cnt_n   = slip_cnt_q;
        align_fail_n = align_fail_q;
        if (!bus.ena) begin
            state_n = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_n      = S_WAIT;
                    slip_cnt_n   = '0;
                    attempts_n   = '0;
                    align_fail_n = 1'b0;
                end
                S_WAIT: begin
                    if (wait_cnt_q == WAIT_W'(WAIT_CYCLES - 1)) begin
                        state_n = S_CHECK;
                    end else begin
                        wait_cnt_n = wait_cnt_q + WAIT_W'(1);
                    end
                end
                S_CHECK: begin
                    if (!frame_match_c) begin
                        state_n    = S_SLIP;
                        attempts_n = attempts_q + ATT_W'(1);
                        slip_cnt_n = (slip_cnt_q == CNT_W'(SERDES_WIDTH - 1))
                                   ? '0 : slip_cnt_q + CNT_W'(1);
                    end else if (match_done_c) begin
                        state_n = S_LOCKED;
                    end
                end
                S_SLIP: begin
                    if (attempts_q == ATT_W'(MAX_ATTEMPTS)) begin
                        state_n      = S_FAIL;
                        align_fail_n = 1'b1;
                    end else begin
                        state_n = S_WAIT;
                    end
                end
                S_LOCKED: begin
                    if (miss_done_c) begin
                        state_n    = S_WAIT;
                        attempts_n = '0;
                    end
                end
                S_FAIL:  state_n = S_FAIL;
                default: state_n = S_IDLE;
            endcase
        end
    end

    // Counters and registered outputs derived from the upcoming state
    always_ff @(posedge slow_clk or posedge reset) begin
        if (reset) begin
            wait_cnt_q   <= '0;
            attempts_q   <= '0;
            slip_cnt_q   <= '0;
            align_fail_q <= 1'b0;
            bitslip_q    <= '0;
            locked_q     <= 1'b0;
            data_valid_q <= 1'b0;
        end else begin
            wait_cnt_q   <= wait_cnt_n;
            attempts_q   <= attempts_n;
            slip_cnt_q   <= slip_cnt_n;
            align_fail_q <= align_fail_n;
            bitslip_q    <= {NUM_LANES{state_n == S_SLIP}};
            locked_q     <= (state_n == S_LOCKED);
            data_valid_q <= (state_n == S_LOCKED);
        end
    end

    assign bus.bitslip       = bitslip_q;
    assign bus.bitslip_count = slip_cnt_q;
    assign bus.locked        = locked_q;
    assign bus.data_valid    = data_valid_q;
    assign bus.align_fail    = align_fail_q;

`ifdef FRAME_RELOCK_EN
    if (1) begin : g_relock
        logic [RELOCK_CNT_W-1:0] relock_q;

        // Saturating count of lock-loss events
        always_ff @(posedge slow_clk or posedge reset) begin
            if (reset) begin
                relock_q <= '0;
            end else if (bus.ena && state_q == S_LOCKED && miss_done_c
                         && relock_q != {RELOCK_CNT_W{1'b1}}) begin
                relock_q <= relock_q + RELOCK_CNT_W'(1);
            end
        end

        assign bus.relock_count = relock_q;
    end
`else
    assign bus.relock_count = '0;
`endif

endmodule

// File: tb/tb_syzygy_adc_frame_align.sv
// Randomized self-checking bench for syzygy_adc_frame_align against a rotation-channel model.
// Define FRAME_RELOCK_EN to exercise the relock path.
module tb_syzygy_adc_frame_align;
    import syzygy_adc_pkg::*;

    localparam int unsigned SW           = 8;
    localparam int unsigned NL           = 4;
    localparam int          SLIP_WAIT    = 4;
    localparam int          CHECK_CYCLES = 4;
    localparam int          MISS_LIMIT   = 4;
    localparam logic [7:0]  PATTERN      = 8'hF0;
    localparam int          SLIP_PERIOD  = SLIP_WAIT + 2;

    logic slow_clk = 1'b0;
    logic reset    = 1'b1;
    int   n_tests  = 0;
    int   n_fail   = 0;

    syzygy_adc_if #(.SERDES_WIDTH(SW), .NUM_LANES(NL)) bus ();

    syzygy_adc_frame_align #(
        .SERDES_WIDTH  (SW),
        .FRAME_PATTERN (PATTERN),
        .NUM_LANES     (NL),
        .SLIP_WAIT     (SLIP_WAIT),
        .CHECK_CYCLES  (CHECK_CYCLES),
        .MISS_LIMIT    (MISS_LIMIT)
    ) dut (
        .slow_clk (slow_clk),
        .reset    (reset),
        .bus      (bus)
    );

    always #5 slow_clk = ~slow_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [7:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    function automatic logic [7:0] rotr8(input logic [7:0] v);
        return {v[0], v[7:1]};
    endfunction

    // Slips the channel needs before the pattern appears; -1 if the attempt budget runs out
    function automatic int slips_needed(input logic [7:0] w);
        logic [7:0] r;
        r = w;
        for (int k = 0; k < 2 * int'(SW); k++) begin
            if (r == PATTERN) return k;
            r = rotr8(r);
        end
        return -1;
    endfunction

    function automatic logic [7:0] bad_word();
        logic [7:0] w;
        do w = 8'($urandom); while (w == PATTERN);
        return w;
    endfunction

    // Enable alignment from IDLE (called just after a falling edge) and compare with the model
    task automatic run_align(input logic [7:0] start_word, input string tag, output int exp_pulses);
        int k, pulses, lock_edge, fail_edge, exp_lock, exp_fail, budget;
        bit pulse_ok, dv_ok;
        logic [7:0] word;
        k          = slips_needed(start_word);
        exp_pulses = (k < 0) ? 2 * int'(SW) : k;
        exp_lock   = (k < 0) ? -1 : 1 + SLIP_WAIT + CHECK_CYCLES + k * SLIP_PERIOD;
        exp_fail   = (k < 0) ? 2 * int'(SW) * SLIP_PERIOD + 1 : -1;
        budget     = 2 * int'(SW) * SLIP_PERIOD + 30;
        word       = start_word;
        pulses     = 0;
        lock_edge  = -1;
        fail_edge  = -1;
        pulse_ok   = 1'b1;
        dv_ok      = 1'b1;
        bus.frame_word = word;
        bus.ena        = 1'b1;
        for (int e = 1; e <= budget; e++) begin
            @(negedge slow_clk);
            if (e == 1) begin
                check_eq({tag, " restart count"}, 32'(bus.bitslip_count), 0);
                check_eq({tag, " restart fail"}, 32'(bus.align_fail), 0);
            end
            if (bus.bitslip != '0) begin
                pulses++;
                if (bus.bitslip !== '1 || e != pulses * SLIP_PERIOD) pulse_ok = 1'b0;
                word = rotr8(word);
                bus.frame_word = word;
            end
            if (bus.locked && lock_edge < 0) lock_edge = e;
            if (bus.align_fail && fail_edge < 0) fail_edge = e;
            if (bus.data_valid !== (exp_lock > 0 && e >= exp_lock)) dv_ok = 1'b0;
            if (lock_edge >= 0 && e >= lock_edge + 2) break;
        end
        check_eq({tag, " pulses"}, 32'(pulses), 32'(exp_pulses));
        check_eq({tag, " pulse timing"}, 32'(pulse_ok), 1);
        check_eq({tag, " lock edge"}, 32'(lock_edge), 32'(exp_lock));
        check_eq({tag, " fail edge"}, 32'(fail_edge), 32'(exp_fail));
        check_eq({tag, " slip count"}, 32'(bus.bitslip_count), 32'(exp_pulses % int'(SW)));
        check_eq({tag, " data_valid"}, 32'(dv_ok), 1);
    endtask

    task automatic drop_ena(input string tag, input int exp_cnt, input bit exp_fail);
        bus.ena = 1'b0;
        @(negedge slow_clk);
        check_eq({tag, " locked"}, 32'(bus.locked), 0);
        check_eq({tag, " data_valid"}, 32'(bus.data_valid), 0);
        check_eq({tag, " bitslip"}, 32'(bus.bitslip), 0);
        check_eq({tag, " held count"}, 32'(bus.bitslip_count), 32'(exp_cnt));
        check_eq({tag, " held fail"}, 32'(bus.align_fail), 32'(exp_fail));
        @(negedge slow_clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int np;
        bit seen;
        logic [7:0] w;
        bus.ena        = 1'b0;
        bus.frame_word = 8'h00;

        repeat (2) @(negedge slow_clk);
        check_eq("reset bitslip", 32'(bus.bitslip), 0);
        check_eq("reset count", 32'(bus.bitslip_count), 0);
        check_eq("reset locked", 32'(bus.locked), 0);
        check_eq("reset data_valid", 32'(bus.data_valid), 0);
        check_eq("reset fail", 32'(bus.align_fail), 0);
        check_eq("reset relock", 32'(bus.relock_count), 0);
        reset = 1'b0;
        @(negedge slow_clk);

        // Aligned channel, then behaviour while locked
        run_align(PATTERN, "aligned", np);
`ifdef FRAME_RELOCK_EN
        for (int i = 0; i < 3; i++) begin
            bus.frame_word = bad_word();
            @(negedge slow_clk);
        end
        bus.frame_word = PATTERN;
        @(negedge slow_clk);
        check_eq("three misses locked", 32'(bus.locked), 1);
        for (int i = 0; i < MISS_LIMIT; i++) begin
            bus.frame_word = bad_word();
            @(negedge slow_clk);
            if (i < MISS_LIMIT - 1) check_eq("miss run locked", 32'(bus.locked), 1);
        end
        check_eq("lock lost", 32'(bus.locked), 0);
        check_eq("lock lost data_valid", 32'(bus.data_valid), 0);
        check_eq("relock count", 32'(bus.relock_count), 1);
        bus.frame_word = PATTERN;
        np = -1;
        for (int e = 1; e <= 20; e++) begin
            @(negedge slow_clk);
            if (bus.locked && np < 0) np = e;
            if (np >= 0) break;
        end
        check_eq("relock latency", 32'(np), 32'(SLIP_WAIT + CHECK_CYCLES));
        check_eq("relock slip count", 32'(bus.bitslip_count), 0);
        check_eq("relock count held", 32'(bus.relock_count), 1);
`else
        for (int i = 0; i < 8; i++) begin
            bus.frame_word = bad_word();
            @(negedge slow_clk);
            check_eq("locked ignores word", 32'(bus.locked), 1);
        end
        check_eq("relock tied off", 32'(bus.relock_count), 0);
        bus.frame_word = PATTERN;
`endif
        drop_ena("drop aligned", 0, 1'b0);

        run_align(rotl8(PATTERN, 3), "rot3", np);
        drop_ena("drop rot3", 3, 1'b0);

        run_align(8'h00, "stuck", np);
        drop_ena("drop stuck", 0, 1'b1);

        // Async reset inside the slip cycle
        bus.frame_word = rotl8(PATTERN, 3);
        bus.ena        = 1'b1;
        seen           = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            @(negedge slow_clk);
            if (bus.bitslip != '0) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("slip seen before reset", 32'(seen), 1);
        check_eq("count before reset", 32'(bus.bitslip_count), 1);
        #1 reset = 1'b1;
        #1;
        check_eq("async bitslip", 32'(bus.bitslip), 0);
        check_eq("async count", 32'(bus.bitslip_count), 0);
        check_eq("async locked", 32'(bus.locked), 0);
        bus.ena = 1'b0;
        @(negedge slow_clk);
        reset = 1'b0;
        run_align(rotl8(PATTERN, 3), "after reset", np);
        drop_ena("drop after reset", 3, 1'b0);

        // Random channels: pattern rotations and arbitrary words
        for (int t = 0; t < 10; t++) begin
            if ($urandom_range(0, 1) == 1) w = rotl8(PATTERN, int'($urandom_range(0, 7)));
            else w = 8'($urandom);
            run_align(w, $sformatf("rand%0d w=%02h", t, w), np);
            drop_ena($sformatf("rand%0d drop", t), np % int'(SW), slips_needed(w) < 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
